// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: drives one external active-low-input full adder
// LSB-first for WIDTH cycles and returns {cout, sum} over a valid/ack handshake.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             valid,
  input  logic             ack,
  output logic             fa_nA,
  output logic             fa_nB,
  output logic             fa_nCin,
  input  logic             fa_S,
  input  logic             fa_Cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_next;

  // Sum bit from the adder enters at the MSB so the LSB-first stream lands in place.
  assign sum_next = {fa_S, sum_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_sh <= sum_next;
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          carry  <= fa_Cout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            sum_out  <= sum_next;
            cout_out <= fa_Cout;
            state    <= DONE;
          end
        end
        DONE: begin
          if (ack) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign valid = (state == DONE);

  // Adder sees logical zeros outside RUN so it stays quiet between additions.
  assign fa_nA   = (state == RUN) ? ~a_sh[0] : 1'b1;
  assign fa_nB   = (state == RUN) ? ~b_sh[0] : 1'b1;
  assign fa_nCin = (state == RUN) ? ~carry   : 1'b1;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a behavioural active-low-input full adder.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             cin_in = 1'b0;
  logic             ready;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;
  logic             valid;
  logic             ack = 1'b0;
  logic             fa_nA;
  logic             fa_nB;
  logic             fa_nCin;
  logic             fa_S;
  logic             fa_Cout;
  logic [1:0]       fa_res;

  int n_cmp = 0;
  int n_bad = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .ready(ready), .sum_out(sum_out), .cout_out(cout_out), .valid(valid), .ack(ack),
    .fa_nA(fa_nA), .fa_nB(fa_nB), .fa_nCin(fa_nCin), .fa_S(fa_S), .fa_Cout(fa_Cout)
  );

  always #5 clk = ~clk;

  assign fa_res  = {1'b0, ~fa_nA} + {1'b0, ~fa_nB} + {1'b0, ~fa_nCin};
  assign fa_S    = fa_res[0];
  assign fa_Cout = fa_res[1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle start once ready is seen; returns with the accept edge consumed.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c);
    for (int i = 0; i < 40 && !ready; i++) step();
    a_in = a; b_in = b; cin_in = c; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Counts edges until valid rises; n = 99 if it never does.
  task automatic wait_valid(output int n);
    n = 99;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (valid) begin n = i; break; end
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_cmp++;
    if ({ready, valid, cout_out, sum_out} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_outputs: got ready=%b valid=%b cout=%b sum=%h, want 1 0 0 00",
               ready, valid, cout_out, sum_out);
    end
    n_cmp++;
    if ({fa_nA, fa_nB, fa_nCin} !== 3'b111) begin
      n_bad++;
      $display("FAIL reset_fa_idle: got %b%b%b, want 111", fa_nA, fa_nB, fa_nCin);
    end
  endtask

  task automatic test_basic();
    logic [7:0] obs_a, obs_b;
    logic       obs_c;
    logic       idle_quiet;
    int         n;
    idle_quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in = 8'hFF; b_in = 8'hFF; cin_in = 1'b1;
      step();
      if ({fa_nA, fa_nB, fa_nCin} !== 3'b111) idle_quiet = 1'b0;
    end
    n_cmp++;
    if (idle_quiet !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_fa_idle: adder inputs toggled in IDLE, want 111");
    end
    issue(8'h5A, 8'h33, 1'b0);
    obs_c = ~fa_nCin;
    for (int i = 0; i < WIDTH; i++) begin
      obs_a[i] = ~fa_nA;
      obs_b[i] = ~fa_nB;
      if (i < WIDTH - 1) begin
        n_cmp++;
        if (valid !== 1'b0) begin
          n_bad++;
          $display("FAIL basic_early_valid: valid=%b at run cycle %0d, want 0", valid, i);
        end
        step();
      end
    end
    n_cmp++;
    if ({obs_a, obs_b, obs_c} !== {8'h5A, 8'h33, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_fa_stream: got a=%h b=%h c=%b, want 5a 33 0", obs_a, obs_b, obs_c);
    end
    wait_valid(n);
    n_cmp++;
    if (n !== 1) begin
      n_bad++;
      $display("FAIL basic_latency: valid after %0d extra edges, want 1", n);
    end
    n_cmp++;
    if ({cout_out, sum_out} !== {1'b0, 8'h8D}) begin
      n_bad++;
      $display("FAIL basic_sum: got cout=%b sum=%h, want 0 8d", cout_out, sum_out);
    end
    n_cmp++;
    if ({fa_nA, fa_nB, fa_nCin, ready} !== 4'b1110) begin
      n_bad++;
      $display("FAIL basic_done_outputs: got fa=%b%b%b ready=%b, want 111 0",
               fa_nA, fa_nB, fa_nCin, ready);
    end
    do_ack();
    n_cmp++;
    if ({ready, valid, sum_out} !== {1'b1, 1'b0, 8'h8D}) begin
      n_bad++;
      $display("FAIL basic_after_ack: got ready=%b valid=%b sum=%h, want 1 0 8d",
               ready, valid, sum_out);
    end
  endtask

  task automatic test_carry();
    int n;
    issue(8'hFF, 8'h01, 1'b0);
    wait_valid(n);
    n_cmp++;
    if ({n, cout_out, sum_out} !== {32'd8, 1'b1, 8'h00}) begin
      n_bad++;
      $display("FAIL carry_ff01: got edges=%0d cout=%b sum=%h, want 8 1 00", n, cout_out, sum_out);
    end
    do_ack();
    issue(8'hFF, 8'hFF, 1'b1);
    wait_valid(n);
    n_cmp++;
    if ({n, cout_out, sum_out} !== {32'd8, 1'b1, 8'hFF}) begin
      n_bad++;
      $display("FAIL carry_ffff1: got edges=%0d cout=%b sum=%h, want 8 1 ff", n, cout_out, sum_out);
    end
    do_ack();
  endtask

  task automatic test_hold();
    int   n;
    logic stable;
    issue(8'h00, 8'h00, 1'b1);
    wait_valid(n);
    n_cmp++;
    if ({cout_out, sum_out} !== {1'b0, 8'h01}) begin
      n_bad++;
      $display("FAIL hold_sum: got cout=%b sum=%h, want 0 01", cout_out, sum_out);
    end
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if ({valid, ready, cout_out, sum_out} !== {1'b1, 1'b0, 1'b0, 8'h01}) stable = 1'b0;
    end
    n_cmp++;
    if (stable !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_stable: got valid=%b ready=%b sum=%h, want 1 0 01 throughout",
               valid, ready, sum_out);
    end
    do_ack();
  endtask

  task automatic test_start_in_run();
    int   n;
    logic quiet;
    issue(8'h10, 8'h20, 1'b0);
    step(); step();
    a_in = 8'hAA; b_in = 8'h55; start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(n);
    n_cmp++;
    if ({n, cout_out, sum_out} !== {32'd5, 1'b0, 8'h30}) begin
      n_bad++;
      $display("FAIL run_start_ignored: got edges=%0d cout=%b sum=%h, want 5 0 30",
               n, cout_out, sum_out);
    end
    do_ack();
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if ({ready, valid} !== 2'b10) quiet = 1'b0;
    end
    n_cmp++;
    if (quiet !== 1'b1) begin
      n_bad++;
      $display("FAIL run_no_queue: got ready=%b valid=%b, want stay idle 1 0", ready, valid);
    end
  endtask

  task automatic test_reset_in_run();
    int n;
    issue(8'h77, 8'h11, 1'b0);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({ready, valid, cout_out, sum_out} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL abort_outputs: got ready=%b valid=%b cout=%b sum=%h, want 1 0 0 00",
               ready, valid, cout_out, sum_out);
    end
    issue(8'h01, 8'h02, 1'b0);
    wait_valid(n);
    n_cmp++;
    if ({n, cout_out, sum_out} !== {32'd8, 1'b0, 8'h03}) begin
      n_bad++;
      $display("FAIL abort_restart: got edges=%0d cout=%b sum=%h, want 8 0 03",
               n, cout_out, sum_out);
    end
    do_ack();
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [4] = '{8'h12, 8'h80, 8'h7F, 8'hF0};
    logic [7:0] vb [4] = '{8'h34, 8'h80, 8'h01, 8'h0F};
    logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [8:0] ve [4] = '{9'h046, 9'h100, 9'h081, 9'h0FF};
    int idx, last;
    idx = 0; last = 0;
    a_in = va[0]; b_in = vb[0]; cin_in = vc[0];
    start = 1'b1; ack = 1'b1;
    for (int cyc = 1; cyc <= 100 && idx < 4; cyc++) begin
      step();
      if (valid) begin
        n_cmp++;
        if ({cout_out, sum_out} !== ve[idx]) begin
          n_bad++;
          $display("FAIL b2b_result%0d: got %h, want %h", idx, {cout_out, sum_out}, ve[idx]);
        end
        if (idx > 0) begin
          n_cmp++;
          if (cyc - last !== 10) begin
            n_bad++;
            $display("FAIL b2b_interval%0d: got %0d cycles, want 10", idx, cyc - last);
          end
        end
        last = cyc;
        idx++;
        if (idx < 4) begin
          a_in = va[idx]; b_in = vb[idx]; cin_in = vc[idx];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    step();
    ack = 1'b0;
    n_cmp++;
    if ({idx, ready} !== {32'd4, 1'b1}) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d results ready=%b, want 4 1", idx, ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_hold();
    test_start_in_run();
    test_reset_in_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
